data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 184 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store from the MEM stage, answers LATENCY cycles later.
// Accepts only in IDLE (stall otherwise); each request occupies IDLE + LATENCY WAIT cycles + one RESP cycle.
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] DATA_BASE   = 32'h0000_2000,
  parameter int          LATENCY     = 2
) (
  input  logic        clockCPU,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          legal_f3;
  logic          misalign;
  logic          req_err;
  logic [31:0]   word;
  logic [31:0]   word_shr;
  logic [15:0]   half;
  logic [7:0]    byte_v;
  logic [31:0]   ld_data;
  logic [3:0]    st_be;
  logic [31:0]   st_data;
  logic          fire;
  logic          commit;

  // Decode works on the captured request, so the request inputs are free after acceptance.
  always_comb begin
    offset   = addr_q - DATA_BASE;
    in_range = (addr_q >= DATA_BASE) && ({1'b0, offset} < MEM_BYTES);
    idx      = offset[AW+1:2];
    if (we_q) legal_f3 = f3_q inside {3'b000, 3'b001, 3'b010};
    else      legal_f3 = f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    misalign = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
               ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    req_err  = !legal_f3 || misalign || !in_range;
  end

  always_comb begin
    word     = mem_q[idx];
    word_shr = word >> {addr_q[1:0], 3'b000};
    byte_v   = word_shr[7:0];
    half     = addr_q[1] ? word[31:16] : word[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{byte_v[7]}}, byte_v};
      3'b001:  ld_data = {{16{half[15]}}, half};
      3'b010:  ld_data = word;
      3'b100:  ld_data = {24'h0, byte_v};
      3'b101:  ld_data = {16'h0, half};
      default: ld_data = 32'h0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    st_be   = 4'b0000;
    st_data = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        st_be   = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        st_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        st_be   = 4'b1111;
        st_data = wdata_q;
      end
      default: begin
        st_be   = 4'b0000;
        st_data = wdata_q;
      end
    endcase
  end

  assign fire   = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign commit = fire && we_q && !req_err;

  // Storage keeps its contents across reset; an async reset drops state to IDLE so no commit fires.
  always_ff @(posedge clockCPU) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem_q[idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clockCPU or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          err_d   = req_err;
          rdata_d = (we_q || req_err) ? 32'h0 : ld_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign stall      = ~req_ready;
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: expected responses are queued at acceptance
// and compared (data, error, latency) when resp_valid appears.
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clockCPU = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  data_mem_responder #(.DEPTH_WORDS(1024), .DATA_BASE(32'h0000_2000), .LATENCY(LAT)) dut (
    .clockCPU  (clockCPU),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .stall     (stall)
  );

  always #5 clockCPU = ~clockCPU;

  int cyc = 0;
  always @(posedge clockCPU) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic prev_vld = 1'b0;

  always @(negedge clockCPU) begin
    if (resp_valid === 1'b1) begin
      if (prev_vld) begin
        checks++; errors++;
        $display("FAIL resp_pulse: resp_valid high for 2 cycles at cycle %0d, required 1", cyc);
      end
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp_unexpected: resp_valid=1 at cycle %0d with no request outstanding", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        checks++;
        if (resp_rdata !== mon_e.rdata || resp_err !== mon_e.err) begin
          errors++;
          $display("FAIL resp_data: got rdata=%h err=%b, required rdata=%h err=%b",
                   resp_rdata, resp_err, mon_e.rdata, mon_e.err);
        end
        checks++;
        if (cyc !== mon_e.acc + LAT) begin
          errors++;
          $display("FAIL resp_latency: response at cycle %0d, required %0d", cyc, mon_e.acc + LAT);
        end
      end
    end
    prev_vld = (resp_valid === 1'b1);
  end

  task automatic drain();
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clockCPU);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    bit acc = 0;
    @(negedge clockCPU);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (req_ready) begin
        @(posedge clockCPU); #1;
        acc = 1;
        sb_q.push_back('{exp_rd, exp_err, cyc});
      end else begin
        @(negedge clockCPU);
      end
    end
    req_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout: addr=%h not accepted, required acceptance", addr);
    end
    drain();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (req_ready !== 1'b1 || stall !== 1'b0 || resp_valid !== 1'b0 ||
        resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b stall=%b vld=%b rdata=%h err=%b, required 1 0 0 0 0",
               req_ready, stall, resp_valid, resp_rdata, resp_err);
    end
    repeat (2) @(negedge clockCPU);
    reset = 1'b0;
  endtask

  task automatic test_store_load();
    send(1'b1, 3'b010, 32'h2000, 32'hDEADBEEF, 32'h0, 1'b0);
    send(1'b0, 3'b010, 32'h2000, 32'h0, 32'hDEADBEEF, 1'b0);
  endtask

  task automatic test_bytes();
    send(1'b1, 3'b000, 32'h2001, 32'h0000_0080, 32'h0, 1'b0);
    send(1'b0, 3'b000, 32'h2001, 32'h0, 32'hFFFF_FF80, 1'b0);
    send(1'b0, 3'b100, 32'h2001, 32'h0, 32'h0000_0080, 1'b0);
    send(1'b0, 3'b010, 32'h2000, 32'h0, 32'hDEAD_80EF, 1'b0);
  endtask

  task automatic test_halves();
    send(1'b1, 3'b001, 32'h2002, 32'h0000_1234, 32'h0, 1'b0);
    send(1'b0, 3'b101, 32'h2002, 32'h0, 32'h0000_1234, 1'b0);
    send(1'b0, 3'b001, 32'h2003, 32'h0, 32'h0, 1'b1);
    send(1'b0, 3'b010, 32'h2002, 32'h0, 32'h0, 1'b1);
    send(1'b0, 3'b001, 32'h2000, 32'h0, 32'hFFFF_80EF, 1'b0);
  endtask

  task automatic test_errors();
    send(1'b1, 3'b010, 32'h3000, 32'hAAAA_5555, 32'h0, 1'b1);
    send(1'b0, 3'b010, 32'h1FFC, 32'h0, 32'h0, 1'b1);
    send(1'b0, 3'b011, 32'h2000, 32'h0, 32'h0, 1'b1);
    send(1'b1, 3'b011, 32'h2000, 32'hFFFF_FFFF, 32'h0, 1'b1);
    send(1'b1, 3'b001, 32'h2001, 32'hFFFF_FFFF, 32'h0, 1'b1);
    send(1'b0, 3'b010, 32'h2000, 32'h0, 32'h1234_80EF, 1'b0);
    send(1'b1, 3'b010, 32'h2FFC, 32'h5A5A_0001, 32'h0, 1'b0);
    send(1'b0, 3'b010, 32'h2FFC, 32'h0, 32'h5A5A_0001, 1'b0);
    send(1'b0, 3'b000, 32'h2FFF, 32'h0, 32'h0000_005A, 1'b0);
  endtask

  task automatic test_hold();
    send(1'b0, 3'b010, 32'h2000, 32'h0, 32'h1234_80EF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clockCPU);
      checks++;
      if (resp_valid !== 1'b0 || resp_rdata !== 32'h1234_80EF || resp_err !== 1'b0) begin
        errors++;
        $display("FAIL resp_hold: vld=%b rdata=%h err=%b, required 0 123480ef 0",
                 resp_valid, resp_rdata, resp_err);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$];
    @(negedge clockCPU);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_wdata = 32'h0;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) @(negedge clockCPU);
      checks++;
      if (stall !== ~req_ready) begin
        errors++;
        $display("FAIL stall_eq: stall=%b ready=%b, required stall = not ready", stall, req_ready);
      end
      if (req_ready) begin
        req_addr = 32'h2000;
        acc_cyc.push_back(cyc + 1);
        sb_q.push_back('{32'h1234_80EF, 1'b0, cyc + 1});
      end else begin
        req_addr = 32'h5000;
      end
    end
    @(negedge clockCPU);
    req_valid = 1'b0;
    checks++;
    if (acc_cyc.size() != 4) begin
      errors++;
      $display("FAIL b2b_count: %0d acceptances in 14 cycles, required 4", acc_cyc.size());
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != LAT + 2) begin
        errors++;
        $display("FAIL b2b_interval: gap %0d cycles, required %0d", acc_cyc[i] - acc_cyc[i-1], LAT + 2);
      end
    end
    drain();
  endtask

  task automatic test_reset_in_wait();
    send(1'b1, 3'b010, 32'h2004, 32'hCAFE_F00D, 32'h0, 1'b0);
    send(1'b0, 3'b010, 32'h2004, 32'h0, 32'hCAFE_F00D, 1'b0);
    @(negedge clockCPU);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h2004; req_wdata = 32'h1111_1111;
    @(posedge clockCPU); #2;
    req_valid = 1'b0;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_accept: stall=%b after store issued, required 1", stall);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0 ||
        req_ready !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: vld=%b rdata=%h err=%b ready=%b stall=%b, required 0 0 0 1 0",
               resp_valid, resp_rdata, resp_err, req_ready, stall);
    end
    repeat (3) @(negedge clockCPU);
    reset = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h2004; req_wdata = 32'h0;
    @(posedge clockCPU); #1;
    req_valid = 1'b0;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL first_accept: stall=%b after first edge past reset, required 1", stall);
    end
    sb_q.push_back('{32'hCAFE_F00D, 1'b0, cyc});
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_load();
    test_bytes();
    test_halves();
    test_errors();
    test_hold();
    test_back_to_back();
    test_reset_in_wait();
    repeat (3) @(negedge clockCPU);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
